// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the word-serial Montgomery datapaths.
package mont_pkg;

    localparam int unsigned WIDTH = 256;
    localparam int unsigned WORD  = 32;
    localparam int unsigned N     = WIDTH / WORD;

    // Digit counter width. It is kept at least one bit so that a single-digit
    // configuration still gets a legal vector.
    function automatic int unsigned counter_w(input int unsigned num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    localparam int unsigned COUNTER_W = counter_w(N);

    typedef enum logic [2:0] {
        StIdle,
        StQcalc,
        StAcc,
        StSub,
        StDone
    } state_t;

endpackage

// File: rtl/mont_word_step.sv
// One Montgomery digit step: (t + q*modulos) >> WORD. The caller picks q so that
// the low WORD bits of the sum are zero, which makes the shift an exact division.
module mont_word_step #(
    parameter int unsigned WIDTH = mont_pkg::WIDTH,
    parameter int unsigned WORD  = mont_pkg::WORD
) (
    input  logic [WIDTH+1:0] t,
    input  logic [WORD-1:0]  q,
    input  logic [WIDTH-1:0] modulos,
    output logic [WIDTH+1:0] t_next
);

    localparam int unsigned SUM_W = WIDTH + WORD + 2;

    logic [SUM_W-1:0] sum;

    // Full-width sum, then drop the zero low digit.
    always_comb begin
        sum    = SUM_W'(t) + (SUM_W'(q) * SUM_W'(modulos));
        t_next = (WIDTH + 2)'(sum >> WORD);
    end

endmodule

// File: rtl/mont_redc.sv
// Word-serial Montgomery reduction: outdata = indata * 2^-WIDTH mod modulos.
// Each digit takes two cycles (q computation, then accumulate-and-shift), followed
// by one conditional subtraction and a DONE cycle, giving 2N+2 cycles per result.
module mont_redc #(
    parameter int unsigned WIDTH = mont_pkg::WIDTH,
    parameter int unsigned WORD  = mont_pkg::WORD
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] indata,
    input  logic [WIDTH-1:0] modulos,
    input  logic [WORD-1:0]  mp,
    output logic [WIDTH-1:0] outdata,
    output logic             busy,
    output logic             end_flag
);

    import mont_pkg::*;

    localparam int unsigned NUM_WORDS = WIDTH / WORD;
    localparam int unsigned CW        = counter_w(NUM_WORDS);
    localparam logic [CW-1:0] LAST    = CW'(NUM_WORDS - 1);

    state_t           state_q, state_d;
    logic [WIDTH+1:0] t_q, t_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WORD-1:0]  mp_q, mp_d;
    logic [WORD-1:0]  q_q, q_d;
    logic [CW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH+1:0] t_step;
    logic [WIDTH+1:0] m_ext;

    mont_word_step #(
        .WIDTH (WIDTH),
        .WORD  (WORD)
    ) u_step (
        .t       (t_q),
        .q       (q_q),
        .modulos (m_q),
        .t_next  (t_step)
    );

    assign m_ext = {2'b00, m_q};

    // Next-state and datapath update for the reduction sequence.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        m_d     = m_q;
        mp_d    = mp_q;
        q_d     = q_q;
        i_d     = i_q;
        out_d   = out_q;
        unique case (state_q)
            // DONE accepts a new request exactly like IDLE, so results can run
            // back-to-back with start held high.
            StIdle, StDone: begin
                if (start) begin
                    t_d     = {2'b00, indata};
                    m_d     = modulos;
                    mp_d    = mp;
                    i_d     = '0;
                    state_d = StQcalc;
                end
            end
            StQcalc: begin
                q_d     = t_q[WORD-1:0] * mp_q;
                state_d = StAcc;
            end
            StAcc: begin
                t_d = t_step;
                if (i_q == LAST) begin
                    state_d = StSub;
                end else begin
                    i_d     = i_q + CW'(1);
                    state_d = StQcalc;
                end
            end
            StSub: begin
                // t < 2*modulos for in-range inputs, so one subtraction suffices.
                if (t_q >= m_ext) begin
                    out_d = WIDTH'(t_q - m_ext);
                end else begin
                    out_d = WIDTH'(t_q);
                end
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            t_q     <= '0;
            m_q     <= '0;
            mp_q    <= '0;
            q_q     <= '0;
            i_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            m_q     <= m_d;
            mp_q    <= mp_d;
            q_q     <= q_d;
            i_q     <= i_d;
            out_q   <= out_d;
        end
    end

    // Status outputs are decoded straight from the state register.
    always_comb begin
        busy     = (state_q == StQcalc) || (state_q == StAcc) || (state_q == StSub);
        end_flag = (state_q == StDone);
        outdata  = out_q;
    end

endmodule

// File: tb/tb_mont_redc.sv
// Scoreboard bench for mont_redc: the driver pushes the model's expected result when
// a request is accepted; a monitor pops and compares on every rising end_flag.
module tb_mont_redc;

    localparam int unsigned W   = 256;
    localparam int unsigned WD  = 32;
    localparam int unsigned LAT = 2 * (W / WD) + 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  indata = '0;
    logic [W-1:0]  modulos = '0;
    logic [WD-1:0] mp = '0;
    logic [W-1:0]  outdata;
    logic          busy;
    logic          end_flag;

    mont_redc #(
        .WIDTH (W),
        .WORD  (WD)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .indata   (indata),
        .modulos  (modulos),
        .mp       (mp),
        .outdata  (outdata),
        .busy     (busy),
        .end_flag (end_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int unsigned  acc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic        prev_end = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W+3:0] got, input logic [W+3:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: x * 2^-W mod m by repeated modular halving.
    function automatic logic [W-1:0] model(input logic [W:0] x, input logic [W-1:0] m);
        logic [W+1:0] r;
        r = {1'b0, x} % {2'b00, m};
        for (int k = 0; k < W; k++) begin
            if (r[0]) r = (r + {2'b00, m}) >> 1;
            else      r = r >> 1;
        end
        return r[W-1:0];
    endfunction

    // -m^-1 mod 2^WD by Newton iteration.
    function automatic logic [WD-1:0] mp_of(input logic [W-1:0] m);
        logic [WD-1:0] inv;
        inv = m[WD-1:0];
        for (int k = 0; k < 5; k++) inv = inv * (WD'(2) - m[WD-1:0] * inv);
        return -inv;
    endfunction

    // Monitor: one comparison set per new result.
    always @(negedge clk) begin
        exp_t e;
        if (end_flag && !prev_end) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {3'b000, end_flag}, '0);
            end else begin
                e = sb.pop_front();
                check("outdata", outdata, e.res);
                check("latency", cyc - e.acc + 1, LAT);
                check("busy_at_done", busy, 0);
            end
        end
        prev_end = end_flag;
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] m, input logic [WD-1:0] p,
                         input logic [W-1:0] res);
        exp_t e;
        indata  = x;
        modulos = m;
        mp      = p;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res = res;
        e.acc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 4 * LAT && !seen; k++) begin
            @(negedge clk);
            if (end_flag) seen = 1'b1;
        end
        check("end_flag_seen", seen, 1);
    endtask

    initial begin
        logic [W-1:0]   m1, m2, r1, r2, x;
        logic [WD-1:0]  p1, p2;
        logic [767:0]   big;
        logic [287:0]   rnd;
        exp_t           e;

        m1  = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013;
        p1  = 32'hd79435e5;
        big = 768'(1) << 256;
        r1  = W'(big % {512'b0, m1});
        big = 768'(1) << 512;
        r2  = W'(big % {512'b0, m1});
        m2  = '0;
        for (int k = 0; k < 8; k++) m2 = {m2[W-33:0], $urandom()};
        m2[W-1] = 1'b1;
        m2[0]   = 1'b1;
        p2 = mp_of(m2);

        repeat (3) @(posedge clk);
        #1;
        check("reset_outdata", outdata, 0);
        check("reset_busy", busy, 0);
        check("reset_end_flag", end_flag, 0);
        rstn = 1'b1;

        // Directed operands.
        issue(r1, m1, p1, 1);                 wait_done();
        issue(r2, m1, p1, r1);                wait_done();
        issue(1, m1, p1, model(1, m1));       wait_done();
        issue(0, m1, p1, 0);                  wait_done();
        issue(m1 + r1, m1, p1, 1);            wait_done();

        // start pulses while busy are ignored.
        issue(r2, m1, p1, r1);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; indata = 1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; indata = 0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // Operand changes mid-operation are not seen.
        issue(r2, m1, p1, r1);
        @(posedge clk);
        #1 indata = ~r2; modulos = m2; mp = p2;
        wait_done();

        // start held high: one accept every LAT cycles.
        indata  = r1;
        modulos = m1;
        mp      = p1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        e.res = 1; e.acc = cyc; sb.push_back(e);
        indata = 0;
        repeat (LAT) @(posedge clk);
        #1;
        e.res = 0; e.acc = cyc; sb.push_back(e);
        indata = r2;
        repeat (LAT) @(posedge clk);
        #1;
        e.res = r1; e.acc = cyc; sb.push_back(e);
        start = 1'b0;
        wait_done();

        // Reset in the middle of an operation.
        issue(1, m1, p1, model(1, m1));
        repeat (8) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        check("midreset_outdata", outdata, 0);
        check("midreset_end_flag", end_flag, 0);
        check("midreset_busy", busy, 0);
        sb.delete();
        issue(r1, m1, p1, 1);
        wait_done();

        // Random regression on both moduli.
        for (int n = 0; n < 1000; n++) begin
            rnd = '0;
            for (int k = 0; k < 9; k++) rnd = {rnd[255:0], $urandom()};
            x = W'(rnd % {31'b0, m1, 1'b0});
            issue(x, m1, p1, model({1'b0, x}, m1));
            wait_done();
        end
        for (int n = 0; n < 200; n++) begin
            for (int k = 0; k < 8; k++) x = {x[W-33:0], $urandom()};
            issue(x, m2, p2, model({1'b0, x}, m2));
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
